// File: rtl/alu_share_arbiter.sv
// Round-robin owner of the shared execute-stage ALU: registers one request, drives the ALU
// for a single cycle, holds the result until consumed, and keeps the {Z,C,N,V} status register.
module alu_share_arbiter #(
    parameter int REGISTER_LEN        = 32,
    parameter int EXECUTE_COMMAND_LEN = 4,
    parameter logic [EXECUTE_COMMAND_LEN-1:0] CMD_TST = EXECUTE_COMMAND_LEN'(8),
    parameter logic [EXECUTE_COMMAND_LEN-1:0] CMD_CMP = EXECUTE_COMMAND_LEN'(10)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req0_valid,
    output logic                           req0_ready,
    input  logic [REGISTER_LEN-1:0]        req0_in1,
    input  logic [REGISTER_LEN-1:0]        req0_in2,
    input  logic [EXECUTE_COMMAND_LEN-1:0] req0_cmd,
    input  logic                           req0_s,
    input  logic                           req1_valid,
    output logic                           req1_ready,
    input  logic [REGISTER_LEN-1:0]        req1_in1,
    input  logic [REGISTER_LEN-1:0]        req1_in2,
    input  logic [EXECUTE_COMMAND_LEN-1:0] req1_cmd,
    input  logic                           req1_s,
    input  logic                           flush,
    output logic [REGISTER_LEN-1:0]        alu_in1,
    output logic [REGISTER_LEN-1:0]        alu_in2,
    output logic [EXECUTE_COMMAND_LEN-1:0] alu_command,
    output logic [3:0]                     status_register,
    input  logic [REGISTER_LEN-1:0]        alu_out,
    input  logic [3:0]                     alu_status_register_out,
    output logic                           rsp_valid,
    output logic                           rsp_id,
    output logic [REGISTER_LEN-1:0]        rsp_result,
    input  logic                           rsp_ready,
    output logic [1:0]                     dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

    state_t                         state_q, state_d;
    logic [REGISTER_LEN-1:0]        in1_q, in1_d, in2_q, in2_d, result_q, result_d;
    logic [EXECUTE_COMMAND_LEN-1:0] cmd_q, cmd_d;
    logic                           s_q, s_d, id_q, id_d, last_grant_q, last_grant_d;
    logic [3:0]                     status_q, status_d;
    logic                           grant0, grant1;

    // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
    // ready never depends on anything but state, valid and flush, and valid must hold until then.
    always_comb begin
        state_d      = state_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        cmd_d        = cmd_q;
        s_d          = s_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        status_d     = status_q;
        result_d     = result_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
        alu_in1      = '0;
        alu_in2      = '0;
        alu_command  = '0;
        rsp_valid    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush) begin
                    // On a tie the port that did not win last time goes first.
                    grant0 = req0_valid && (!req1_valid || last_grant_q);
                    grant1 = req1_valid && !grant0;
                end
                if (grant0 || grant1) begin
                    in1_d        = grant0 ? req0_in1 : req1_in1;
                    in2_d        = grant0 ? req0_in2 : req1_in2;
                    cmd_d        = grant0 ? req0_cmd : req1_cmd;
                    s_d          = grant0 ? req0_s   : req1_s;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_in1     = in1_q;
                alu_in2     = in2_q;
                alu_command = cmd_q;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = alu_out;
                    if (s_q || cmd_q == CMD_CMP || cmd_q == CMD_TST) begin
                        status_d = alu_status_register_out;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // A flushed response is withdrawn in the same cycle so it cannot be consumed.
                rsp_valid = !flush;
                if (flush || rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            in1_q        <= '0;
            in2_q        <= '0;
            cmd_q        <= '0;
            s_q          <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            status_q     <= 4'b0000;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            cmd_q        <= cmd_d;
            s_q          <= s_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            status_q     <= status_d;
            result_q     <= result_d;
        end
    end

    assign req0_ready      = grant0 && rst;
    assign req1_ready      = grant1 && rst;
    assign status_register = status_q;
    assign rsp_id          = id_q;
    assign rsp_result      = result_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised scoreboard bench for alu_share_arbiter with a behavioural ALU and a
// transaction-level model of arbitration, serial execution and status-register updates.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    localparam int W = 32;
    localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_ADD = 4'h4,
                           OP_ADC = 4'h5, OP_SBC = 4'h6, OP_TST = 4'h8, OP_CMP = 4'hA,
                           OP_ORR = 4'hC, OP_MOV = 4'hD;
    localparam logic [3:0] CMDS [10] = '{OP_AND, OP_EOR, OP_SUB, OP_ADD, OP_ADC,
                                         OP_SBC, OP_TST, OP_CMP, OP_ORR, OP_MOV};

    typedef struct packed {
        logic [3:0]   cmd;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
    } op_t;

    logic         clk, rst, flush;
    logic         req0_valid, req0_ready, req0_s, req1_valid, req1_ready, req1_s;
    logic [W-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [3:0]   req0_cmd, req1_cmd, alu_command, status_register, alu_status_register_out;
    logic [W-1:0] alu_in1, alu_in2, alu_out, rsp_result;
    logic         rsp_valid, rsp_id, rsp_ready;
    logic [1:0]   dbg_state;
    logic [35:0]  alu_res;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [3:0]   m_status;
    logic         m_last;
    logic         rand_rr;
    op_t          q0[$];
    op_t          q1[$];
    logic [36:0]  exp_q[$];   // {id, status after op, result}

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
        .req0_in2(req0_in2), .req0_cmd(req0_cmd), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
        .req1_in2(req1_in2), .req1_cmd(req1_cmd), .req1_s(req1_s),
        .flush(flush), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_command(alu_command),
        .status_register(status_register), .alu_out(alu_out),
        .alu_status_register_out(alu_status_register_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_ready(rsp_ready), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Behavioural ALU: returns {Z,C,N,V, result}; C is the no-borrow carry for subtraction.
    function automatic logic [35:0] alu_ref(input logic [3:0] cmd, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        logic [W:0]   sum;
        logic [W-1:0] r, bb;
        logic         c, v, cc, arith;
        arith = 1'b1;
        bb    = b;
        cc    = 1'b0;
        c     = cin;
        v     = 1'b0;
        r     = '0;
        case (cmd)
            OP_ADD:         ;
            OP_ADC:         cc = cin;
            OP_SUB, OP_CMP: begin bb = ~b; cc = 1'b1; end
            OP_SBC:         begin bb = ~b; cc = cin;  end
            default:        arith = 1'b0;
        endcase
        if (arith) begin
            sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
            r   = sum[W-1:0];
            c   = sum[W];
            v   = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            case (cmd)
                OP_AND, OP_TST: r = a & b;
                OP_EOR:         r = a ^ b;
                OP_ORR:         r = a | b;
                OP_MOV:         r = b;
                default:        r = '0;
            endcase
        end
        return {(r == '0), c, r[W-1], v, r};
    endfunction

    always_comb begin
        alu_res                 = alu_ref(alu_command, alu_in1, alu_in2, status_register[2]);
        alu_out                 = alu_res[W-1:0];
        alu_status_register_out = alu_res[35:32];
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout required event (t=%0t)", name, $time);
    endtask

    function automatic op_t mk_op(input logic [3:0] cmd, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic s);
        op_t o;
        o.cmd = cmd;
        o.a   = a;
        o.b   = b;
        o.s   = s;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.cmd = CMDS[$urandom_range(0, 9)];
        o.a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
        o.b   = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom();
        o.s   = 1'($urandom_range(0, 1));
        return o;
    endfunction

    // Reference model: ops complete one at a time in grant order.
    task automatic accept(input int port, input op_t op);
        logic [35:0] r;
        r = alu_ref(op.cmd, op.a, op.b, m_status[2]);
        if (op.s || op.cmd == OP_CMP || op.cmd == OP_TST) m_status = r[35:32];
        exp_q.push_back({1'(port), m_status, r[W-1:0]});
        m_last = 1'(port);
    endtask

    task automatic drive_port(input int port, input logic v, input op_t op);
        if (port == 0) begin
            req0_valid = v; req0_cmd = op.cmd; req0_in1 = op.a; req0_in2 = op.b; req0_s = op.s;
        end else begin
            req1_valid = v; req1_cmd = op.cmd; req1_in1 = op.a; req1_in2 = op.b; req1_s = op.s;
        end
    endtask

    task automatic wait_ready(output int port);
        port = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req0_ready) begin port = 0; break; end
            if (req1_ready) begin port = 1; break; end
        end
        if (port < 0) fail_now("grant_timeout");
    endtask

    task automatic wait_rsp();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        if (!seen) fail_now("rsp_timeout");
    endtask

    task automatic run_queues();
        int port, exp_port;
        while (q0.size() > 0 || q1.size() > 0) begin
            drive_port(0, q0.size() > 0, (q0.size() > 0) ? q0[0] : '0);
            drive_port(1, q1.size() > 0, (q1.size() > 0) ? q1[0] : '0);
            if (q0.size() > 0 && q1.size() > 0) exp_port = m_last ? 0 : 1;
            else                                exp_port = (q0.size() > 0) ? 0 : 1;
            wait_ready(port);
            if (port < 0) begin
                q0.delete();
                q1.delete();
                break;
            end
            chk("grant_port", port, exp_port);
            if (port == 0) begin accept(0, q0[0]); void'(q0.pop_front()); end
            else           begin accept(1, q1[0]); void'(q1.pop_front()); end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst && rsp_valid) begin
                chk("alu_idle_in_resp", 64'(alu_command) | 64'(alu_in1) | 64'(alu_in2), 0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id=%0d result=%0h required no response",
                             rsp_id, rsp_result);
                end else begin
                    chk("rsp_id", rsp_id, exp_q[0][36]);
                    chk("rsp_status", status_register, exp_q[0][35:32]);
                    chk("rsp_result", rsp_result, exp_q[0][31:0]);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rr) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int port;
        rst = 1'b0; flush = 1'b0; rsp_ready = 1'b1; rand_rr = 1'b0;
        m_status = 4'b0000; m_last = 1'b1;
        drive_port(0, 1'b1, mk_op(OP_ADD, 1, 2, 1'b1));
        drive_port(1, 1'b1, mk_op(OP_ADD, 3, 4, 1'b1));
        repeat (3) @(negedge clk);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_status", status_register, 0);
        chk("rst_alu_cmd", 64'(alu_command) | 64'(alu_in1) | 64'(alu_in2), 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Both ports busy from the first cycle: grants alternate starting with port 0.
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        run_queues();
        drain();

        // ADD 5+7 with latency: ready at T, nothing at T+1, response at T+2.
        @(posedge clk); #1;
        drive_port(0, 1'b1, mk_op(OP_ADD, 5, 7, 1'b1));
        @(negedge clk);
        chk("lat_ready0_T", req0_ready, 1);
        if (req0_ready) accept(0, mk_op(OP_ADD, 5, 7, 1'b1));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("lat_exec_no_rsp", rsp_valid, 0);
        @(negedge clk);
        chk("lat_rsp_valid_T2", rsp_valid, 1);
        chk("add_5_7", rsp_result, 12);
        chk("add_status", status_register, 4'b0000);
        drain();

        // Carry chain: 0xFFFFFFFF+1 sets Z and C, ADC consumes C, s=0 leaves status.
        q0.push_back(mk_op(OP_ADD, 32'hFFFF_FFFF, 1, 1'b1));
        q0.push_back(mk_op(OP_ADC, 0, 0, 1'b0));
        run_queues();
        drain();
        chk("carry_status", status_register, 4'b1100);

        // CMP writes flags even with s=0; AND with s=0 does not.
        q0.push_back(mk_op(OP_ADD, 32'h8000_0000, 0, 1'b1));
        q0.push_back(mk_op(OP_CMP, 3, 3, 1'b0));
        q0.push_back(mk_op(OP_AND, 32'hF0, 32'h0F, 1'b0));
        run_queues();
        drain();
        chk("cmp_z_bit", status_register[3], 1);
        chk("and_s0_status", status_register, 4'b1100);

        // Consumer stall with port 1 waiting.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_port(0, 1'b1, mk_op(OP_ORR, 32'h1234, 32'h8000, 1'b0));
        wait_ready(port);
        chk("hold_grant0", port, 0);
        if (port == 0) accept(0, mk_op(OP_ORR, 32'h1234, 32'h8000, 1'b0));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive_port(1, 1'b1, mk_op(OP_MOV, 0, 32'hCAFE, 1'b0));
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ready1_low", req1_ready, 0);
            chk("hold_rsp_valid", rsp_valid, 1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_ready1_resp", req1_ready, 0);
        @(negedge clk);
        chk("release_ready1_next", req1_ready, 1);
        if (req1_ready) accept(1, mk_op(OP_MOV, 0, 32'hCAFE, 1'b0));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();

        // Flush during EXEC of SUB s=1: no response, no flag write.
        @(posedge clk); #1;
        drive_port(0, 1'b1, mk_op(OP_SUB, 10, 3, 1'b1));
        wait_ready(port);
        chk("flush_grant0", port, 0);
        m_last = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_exec_no_rsp", rsp_valid, 0);
        end
        chk("flush_exec_status", status_register, m_status);

        // Flush in IDLE blocks the grant for that cycle only.
        @(posedge clk); #1;
        drive_port(0, 1'b1, mk_op(OP_ADD, 1, 1, 1'b0));
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready0", req0_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("after_flush_ready0", req0_ready, 1);
        if (req0_ready) accept(0, mk_op(OP_ADD, 1, 1, 1'b0));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drain();

        // Flush in RESP drops the held response.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_port(1, 1'b1, mk_op(OP_EOR, 32'hFF, 32'h0F, 1'b0));
        wait_ready(port);
        chk("flush_resp_grant1", port, 1);
        if (port == 1) accept(1, mk_op(OP_EOR, 32'hFF, 32'h0F, 1'b0));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp();
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_resp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_resp_dropped", rsp_valid, 0);
        end

        // Randomised traffic with a randomly stalling consumer.
        @(posedge clk); #1;
        rand_rr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) q0.push_back(rand_op());
            else                           q1.push_back(rand_op());
        end
        run_queues();
        rand_rr = 1'b0;
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        drain();

        // Reset asserted while a response is held.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_port(1, 1'b1, mk_op(OP_ADD, 32'h8000_0000, 0, 1'b1));
        wait_ready(port);
        if (port == 1) accept(1, mk_op(OP_ADD, 32'h8000_0000, 0, 1'b1));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp();
        chk("pre_rst_status", status_register, 4'b0010);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_status", status_register, 0);
        chk("midrst_result", rsp_result, 0);
        chk("midrst_state", dbg_state, 0);
        exp_q.delete();
        m_status = 4'b0000;
        m_last   = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // After reset the first tie again goes to port 0.
        @(posedge clk); #1;
        q0.push_back(mk_op(OP_ADD, 5, 7, 1'b1));
        q1.push_back(mk_op(OP_SBC, 9, 4, 1'b1));
        run_queues();
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin controller that shares the single execute-stage ALU between two requesters (port 0: execute pipeline, port 1: auxiliary address/compare unit). It registers operands, drives the ALU for one cycle, holds the result until it is consumed, and owns the 4-bit status register {Z,C,N,V} fed back to the ALU as carry-in. It sits between the requesters and the combinational ALU; nothing else writes the status register.

## Interface
- REGISTER_LEN, 32, operand/result width
- EXECUTE_COMMAND_LEN, 4, ALU command width
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_in1, req0_in2 / req1_in1, req1_in2  in  REGISTER_LEN  operands
- req0_cmd / req1_cmd  in  EXECUTE_COMMAND_LEN  ALU command (codebase command defines)
- req0_s / req1_s  in  1  update status register with this op's flags
- flush  in  1  abort in-flight op
- alu_in1, alu_in2  out  REGISTER_LEN  to ALU
- alu_command  out  EXECUTE_COMMAND_LEN  to ALU
- status_register  out  4  current flags {Z,C,N,V}, to ALU and pipeline
- alu_out  in  REGISTER_LEN  ALU result
- alu_status_register_out  in  4  ALU flags {Z,C,N,V}
- rsp_valid  out  1  result available
- rsp_id  out  1  requester that owns the result
- rsp_result  out  REGISTER_LEN  captured alu_out
- rsp_ready  in  1  consumer takes result when rsp_valid&rsp_ready

## Operation
- FSM: IDLE, EXEC, RESP. Reset -> IDLE.
- IDLE: grant arbitration among valid requesters; granted reqN_ready=1 combinationally, other ready=0. On handshake latch in1, in2, cmd, s, id into operand registers; -> EXEC. No valid -> stay IDLE.
- Arbitration: only one valid -> it wins. Both valid -> requester != last_grant wins. last_grant updates on every handshake; reset value 1 (port 0 wins first tie).
- EXEC (one cycle): alu_in1/alu_in2/alu_command driven from operand registers; capture alu_out into rsp_result. Flag write when s=1 or cmd is `CMP or `TST: status_register <= alu_status_register_out. -> RESP.
- Outside EXEC alu_command = 0 and alu_in1/alu_in2 = 0 (ALU idle; flags ignored).
- RESP: rsp_valid=1, rsp_id/rsp_result stable. rsp_ready=1 -> IDLE. No new request accepted in RESP (no bypass to IDLE grant in same cycle).
- flush: in EXEC -> IDLE, no flag write, no response. In RESP -> drop response, -> IDLE. In IDLE: reqN_ready forced 0 that cycle. flush dominates rsp_ready.
- C bit (status_register[2]) is the carry-in consumed by ADC/SBC; flags written in EXEC are visible to the next op's EXEC.

## Timing
- Reset values: state IDLE, status_register 4'b0000, rsp_valid 0, rsp_id 0, rsp_result 0, alu_in1/alu_in2/alu_command 0, last_grant 1, req ready 0 while rst low.
- Reset asserted mid-operation: immediate return to reset values, in-flight op lost, flags cleared.
- Latency: handshake cycle T, EXEC T+1, rsp_valid high from T+2. Minimum issue interval 3 cycles (handshake, EXEC, RESP with rsp_ready=1).
- rsp_valid held with stable data indefinitely while rsp_ready=0.
- status_register changes only at end of EXEC cycle (or reset).

## Test plan
- Reset release, req0 ADD in1=5 in2=7 s=1 -> ready0 at T, rsp_valid T+2, rsp_result=12, rsp_id=0, status=0000.
- Both valid from first cycle, 4 requests each -> grants alternate 0,1,0,1..., each rsp_id matches grant order.
- req0 ADD 0xFFFFFFFF+1 s=1, then ADC 0+0 s=0 -> flags Z=1,C=1 (status 1100); ADC result=1; status unchanged after ADC.
- CMP in1=3 in2=3 s=0 -> status Z=1 written; AND with s=0 afterwards -> status unchanged.
- rsp_ready held 0 for 5 cycles with req1 valid -> rsp_result stable, ready1=0 throughout; release -> req1 accepted next cycle.
- flush in EXEC of SUB s=1 -> no rsp_valid, status unchanged; rst pulsed low during RESP -> rsp_valid=0, status=0000 immediately.
